// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops fifo words and serialises them as 8N1-style UART frames
module fifo_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 104
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_re,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic                  tx,
    output logic                  busy
);

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_MAX  = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state;
    logic [BW-1:0]         baud_cnt;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;

    logic baud_last;
    logic bit_last;

    assign baud_last = (baud_cnt == BAUD_MAX);
    assign bit_last  = (bit_cnt == BIT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            fifo_re  <= 1'b0;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && !fifo_empty) begin
                        state   <= POP;
                        fifo_re <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                POP: begin
                    fifo_re <= 1'b0;
                    state   <= LOAD;
                end
                // fifo_q is valid now, one cycle after the read enable was sampled
                LOAD: begin
                    shift    <= fifo_q;
                    tx       <= 1'b0;
                    baud_cnt <= '0;
                    state    <= START;
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_last) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    fifo_re <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx with a queue-based fifo model
module tb_fifo_uart_tx;

    localparam int CD = 4;
    localparam int DW = 8;
    localparam int NL = DW + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic fifo_empty = 1'b1;
    logic [DW-1:0] fifo_q = '0;
    logic fifo_re, tx, busy;

    logic en2 = 1'b0;
    logic fifo_empty2 = 1'b1;
    logic [4:0] fifo_q2 = '0;
    logic fifo_re2, tx2, busy2;

    int total = 0;
    int bad = 0;
    int pops = 0;
    int exp_pops = 0;
    int underflow = 0;
    int re_cycles = 0;
    int re2_cycles = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] model[$];

    typedef struct {
        logic [7:0] word;
        logic [9:0] levels;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
        .fifo_re(fifo_re), .fifo_q(fifo_q), .tx(tx), .busy(busy)
    );

    fifo_uart_tx #(.DATA_WIDTH(5), .CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .fifo_empty(fifo_empty2),
        .fifo_re(fifo_re2), .fifo_q(fifo_q2), .tx(tx2), .busy(busy2)
    );

    // fifo read port: a read enable seen at an edge returns data just after it
    initial begin : fifo_model
        bit re_seen;
        forever begin
            @(negedge clk);
            re_seen = fifo_re;
            @(posedge clk);
            #1;
            if (re_seen) begin
                if (fq.size() > 0) begin
                    fifo_q = fq.pop_front();
                    pops++;
                end else begin
                    underflow++;
                end
            end
            fifo_empty = (fq.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (fifo_re) re_cycles++;
        if (fifo_re2) re2_cycles++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        exp_pops++;
    endtask

    task automatic get_frame(output logic [NL-1:0] lv, output int gap, output bit stable,
                             output bit busy_ok, output bit found);
        int n;
        gap = 0; stable = 1; busy_ok = 1; found = 0; lv = '1; n = 0;
        while (tx !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
            if (tx === 1'b1) gap++;
        end
        if (tx !== 1'b0) return;
        found = 1;
        for (int i = 0; i < NL; i++) begin
            for (int c = 0; c < CD; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (c == 0) lv[i] = tx;
                else if (tx !== lv[i]) stable = 0;
                if (busy !== 1'b1) busy_ok = 0;
            end
        end
    endtask

    task automatic frame_check(input string name, input logic [NL-1:0] exp_lv, input bit chk_gap);
        logic [NL-1:0] lv;
        int gap;
        bit st, bo, found;
        get_frame(lv, gap, st, bo, found);
        check({name, " found"}, 32'(found), 1);
        if (!found) return;
        check({name, " levels"}, 32'(lv), 32'(exp_lv));
        check({name, " stable"}, 32'(st), 1);
        check({name, " busy"}, 32'(bo), 1);
        if (chk_gap) check({name, " gap"}, gap, 3);
    endtask

    task automatic frame2(input string name, input logic [4:0] w, input logic [6:0] exp_lv);
        logic [6:0] lv;
        bit st;
        int n;
        lv = '1; st = 1; n = 0;
        @(negedge clk);
        fifo_q2 = w; fifo_empty2 = 1'b0; en2 = 1'b1;
        @(negedge clk);
        fifo_empty2 = 1'b1; en2 = 1'b0;
        while (tx2 !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " found"}, 32'(tx2 === 1'b0), 1);
        for (int i = 0; i < 7; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (c == 0) lv[i] = tx2;
                else if (tx2 !== lv[i]) st = 0;
            end
        end
        check({name, " levels"}, 32'(lv), 32'(exp_lv));
        check({name, " stable"}, 32'(st), 1);
        @(negedge clk);
        check({name, " idle"}, {30'd0, tx2, busy2}, 32'b10);
    endtask

    initial begin : main
        int n;
        int errs;
        int k;
        logic [DW-1:0] w;

        vecs[0] = '{word: 8'hA5, levels: 10'b1101001010};
        vecs[1] = '{word: 8'h00, levels: 10'b1000000000};
        vecs[2] = '{word: 8'hFF, levels: 10'b1111111110};
        vecs[3] = '{word: 8'h3C, levels: 10'b1001111000};

        #1 rst = 1'b1;
        #1;
        check("rst tx", 32'(tx), 1);
        check("rst busy", 32'(busy), 0);
        check("rst fifo_re", 32'(fifo_re), 0);
        check("rst tx2", 32'(tx2), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        en = 1'b1;
        foreach (vecs[i]) begin
            push(vecs[i].word);
            frame_check($sformatf("vec%0d", i), vecs[i].levels, 0);
            @(negedge clk);
            check($sformatf("vec%0d idle busy", i), 32'(busy), 0);
        end

        push(8'h00);
        push(8'hFF);
        frame_check("b2b first", 10'b1000000000, 0);
        frame_check("b2b second", 10'b1111111110, 1);

        errs = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_re !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("empty idle", errs, 0);
        push(8'h3C);
        n = 0;
        while (fifo_empty && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 3);
        frame_check("lat frame", 10'b1001111000, 0);

        @(negedge clk);
        en = 1'b0;
        push(8'h81);
        push(8'h42);
        errs = 0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_re !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("en0 no pop", errs, 0);
        check("en0 fifo size", fq.size(), 2);
        en = 1'b1;
        fork
            begin
                repeat (23) @(negedge clk);
                en = 1'b0;
            end
        join_none
        frame_check("en drop frame", 10'b1100000010, 0);
        errs = 0;
        repeat (50) begin
            @(negedge clk);
            if (fifo_re !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("en drop stays idle", errs, 0);
        check("en drop word kept", fq.size(), 1);
        en = 1'b1;
        frame_check("en resume", 10'b1010000100, 0);

        push(8'h52);
        push(8'h99);
        n = 0;
        while (tx !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4 * CD + 1) @(negedge clk);
        check("pre-rst bit3", 32'(tx), 0);
        #1 rst = 1'b1;
        #1;
        check("async rst tx", 32'(tx), 1);
        check("async rst busy", 32'(busy), 0);
        check("async rst fifo_re", 32'(fifo_re), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frame_check("post rst", 10'b1100110010, 0);
        errs = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) errs++;
        end
        check("no resend", errs, 0);

        for (int g = 0; g < 4; g++) begin
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                w = DW'($urandom);
                push(w);
                model.push_back(w);
            end
            for (int j = 0; j < k; j++) begin
                w = model.pop_front();
                frame_check($sformatf("rand g%0d f%0d", g, j), {1'b1, w, 1'b0}, j > 0);
            end
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        frame2("dw5 0x15", 5'h15, 7'b1101010);
        frame2("dw5 0x0A", 5'h0A, 7'b1010100);

        repeat (5) @(negedge clk);
        check("pop count", pops, exp_pops);
        check("underflow", underflow, 0);
        check("re one cycle each", re_cycles, pops);
        check("fifo drained", fq.size(), 0);
        check("dw5 re pulses", re2_cycles, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
